// File: rtl/bcd_counter_n.sv
// Multi-digit packed-BCD up/down counter with programmable wrap limit, synchronous
// clear, validated parallel load and one-cycle done/wrap/err handshake pulses.
module bcd_counter_n #(
  parameter int                    DIGITS  = 2,
  parameter logic [4*DIGITS-1:0]   MAX_BCD = 'h49
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  inc_tick,
  input  logic                  dec_tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  done_tick,
  output logic                  wrap_tick,
  output logic                  err_tick
);

  localparam int W = 4 * DIGITS;

  for (genvar g = 0; g < DIGITS; g++) begin : g_max_chk
    if (MAX_BCD[4*g +: 4] > 4'd9) begin : g_bad_nibble
      $error("bcd_counter_n: MAX_BCD digit %0d is not a BCD digit", g);
    end
  end

  typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;

  state_t         state;
  logic           wrap_q;
  logic           err_q;

  function automatic logic is_valid(input logic [W-1:0] v);
    logic ok;
    ok = (v <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Ripple a carry digit by digit: a 9 rolls to 0 and passes the carry on.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (clr) begin
        state  <= IDLE;
        count  <= '0;
        wrap_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (load) begin
              if (is_valid(load_val)) begin
                count  <= load_val;
                wrap_q <= 1'b0;
                state  <= DONE;
              end else begin
                err_q <= 1'b1;
              end
            end else if (inc_tick && !dec_tick) begin
              if (count == MAX_BCD) begin
                count  <= '0;
                wrap_q <= 1'b1;
              end else begin
                count  <= bcd_inc(count);
                wrap_q <= 1'b0;
              end
              state <= DONE;
            end else if (dec_tick && !inc_tick) begin
              if (count == '0) begin
                count  <= MAX_BCD;
                wrap_q <= 1'b1;
              end else begin
                count  <= bcd_dec(count);
                wrap_q <= 1'b0;
              end
              state <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // DONE is a single state bit, so the decode below cannot glitch.
  assign done_tick = (state == DONE);
  assign wrap_tick = (state == DONE) && wrap_q;
  assign err_tick  = err_q;

endmodule
